// File: rtl/edge_count_divider.sv
// Counts qualified edges of a slow strobe in the clk domain, with prescaler,
// up/down wrap or saturate counting, load/clear and a terminal-count pulse.
module edge_count_divider #(
   parameter int CNT_W    = 2,
   parameter int CNT_MAX  = 3,
   parameter int WRAP_VAL = 1,
   parameter int EDGE_SEL = 0,
   parameter int PRESCALE = 1,
   parameter int SYNC_IN  = 0,
   parameter int MODE     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             en_d,
   input  logic             up_dn,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] count,
   output logic             tc,
   output logic             edge_out
);

   localparam logic [CNT_W-1:0] MAX_V    = CNT_W'(CNT_MAX);
   localparam logic [CNT_W-1:0] WRAP_V   = CNT_W'(WRAP_VAL);
   localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam int               ARM_N    = (SYNC_IN != 0) ? 3 : 1;

   generate
      if (CNT_MAX >= (2 ** CNT_W) || WRAP_VAL > CNT_MAX || WRAP_VAL < 0 ||
          PRESCALE < 1 || EDGE_SEL < 0 || EDGE_SEL > 2) begin : g_param_check
         $error("edge_count_divider: illegal parameter combination");
      end
   endgenerate

   logic             enable_s;
   logic             enable_dly;
   logic             raw_edge;
   logic             edge_det;
   logic             step;
   logic [PRE_W-1:0] pre_cnt;
   logic [ARM_N-1:0] arm_p;

   function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] v);
      return (v > MAX_V) ? MAX_V : v;
   endfunction

   // Returns {tc, count} for a step cycle; wrap or saturate at both terminals.
   function automatic logic [CNT_W:0] next_step(input logic [CNT_W-1:0] cur,
                                                input logic en, input logic up);
      logic [CNT_W-1:0] nxt;
      if (!en)
         return {1'b0, {CNT_W{1'b0}}};
      if (up) begin
         if (cur >= MAX_V)
            return (MODE == 0) ? {1'b1, WRAP_V} : {1'b0, cur};
         nxt = cur + 1'b1;
         return {(MODE != 0) && (nxt == MAX_V), nxt};
      end
      if (cur <= WRAP_V)
         return (MODE == 0) ? {1'b1, MAX_V} : {1'b0, cur};
      nxt = cur - 1'b1;
      return {(MODE != 0) && (nxt == WRAP_V), nxt};
   endfunction

   // Input stage: optional two-flop synchroniser
   generate
      if (SYNC_IN != 0) begin : g_sync
         logic sync_p0;
         logic sync_p1;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               sync_p0 <= 1'b0;
               sync_p1 <= 1'b0;
            end else begin
               sync_p0 <= enable;
               sync_p1 <= sync_p0;
            end
         end
         assign enable_s = sync_p1;
      end else begin : g_nosync
         assign enable_s = enable;
      end
   endgenerate

   // Edge stage: arm_p keeps edges masked until the input path has refilled
   // after reset, so a strobe already high at release is not counted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         enable_dly <= 1'b0;
         arm_p      <= '0;
      end else begin
         enable_dly <= enable_s;
         arm_p      <= ARM_N'({arm_p, 1'b1});
      end
   end

   always_comb begin
      raw_edge = 1'b0;
      if (EDGE_SEL == 0)
         raw_edge = enable_s & ~enable_dly;
      else if (EDGE_SEL == 1)
         raw_edge = ~enable_s & enable_dly;
      else
         raw_edge = enable_s ^ enable_dly;
      edge_det = raw_edge & arm_p[ARM_N-1];
   end

   assign step = edge_det & (pre_cnt == PRE_LAST);

   // Count stage: clear > load > step
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= '0;
         tc       <= 1'b0;
         edge_out <= 1'b0;
         pre_cnt  <= '0;
      end else begin
         edge_out <= edge_det;
         if (clear) begin
            count   <= '0;
            pre_cnt <= '0;
            tc      <= 1'b0;
         end else if (load) begin
            count   <= clamp_load(load_val);
            pre_cnt <= '0;
            tc      <= 1'b0;
         end else begin
            if (edge_det)
               pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
            if (step)
               {tc, count} <= next_step(count, en_d, up_dn);
            else
               tc <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_edge_count_divider.sv
// Directed bench for edge_count_divider: four parameterisations driven side by side.
module tb_edge_count_divider;

   logic clk = 1'b0;
   logic reset;
   logic enable_a, en_d_a, up_dn_a, clear_a, load_a;
   logic [1:0] load_val_a;
   logic enable_b, en_d_b, up_dn_b, clear_b, load_b;
   logic [3:0] load_val_b;
   logic up_dn_c, load_c;
   logic [2:0] load_val_c;

   logic [1:0] cnt_def, cnt_syn;
   logic [3:0] cnt_pre;
   logic [2:0] cnt_sat;
   logic tc_def, tc_syn, tc_pre, tc_sat;
   logic eo_def, eo_syn, eo_pre, eo_sat;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   edge_count_divider u_def (
      .clk(clk), .reset(reset), .enable(enable_a), .en_d(en_d_a), .up_dn(up_dn_a),
      .clear(clear_a), .load(load_a), .load_val(load_val_a),
      .count(cnt_def), .tc(tc_def), .edge_out(eo_def));

   edge_count_divider #(.SYNC_IN(1)) u_syn (
      .clk(clk), .reset(reset), .enable(enable_a), .en_d(en_d_a), .up_dn(up_dn_a),
      .clear(clear_a), .load(load_a), .load_val(load_val_a),
      .count(cnt_syn), .tc(tc_syn), .edge_out(eo_syn));

   edge_count_divider #(.CNT_W(4), .CNT_MAX(9), .WRAP_VAL(0), .EDGE_SEL(2), .PRESCALE(3)) u_pre (
      .clk(clk), .reset(reset), .enable(enable_b), .en_d(en_d_b), .up_dn(up_dn_b),
      .clear(clear_b), .load(load_b), .load_val(load_val_b),
      .count(cnt_pre), .tc(tc_pre), .edge_out(eo_pre));

   edge_count_divider #(.CNT_W(3), .CNT_MAX(3), .WRAP_VAL(1), .MODE(1)) u_sat (
      .clk(clk), .reset(reset), .enable(enable_b), .en_d(en_d_b), .up_dn(up_dn_c),
      .clear(clear_b), .load(load_c), .load_val(load_val_c),
      .count(cnt_sat), .tc(tc_sat), .edge_out(eo_sat));

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_a(input string tag, input int ec, input int et);
      enable_a = 1'b1;
      tick();
      chk({tag, "_cnt"}, int'(cnt_def), ec);
      chk({tag, "_tc"}, int'(tc_def), et);
      tick();
      enable_a = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int exp_cnt [6] = '{1, 2, 3, 1, 2, 3};
      int exp_tc  [6] = '{0, 0, 0, 1, 0, 0};
      int prev;
      reset = 1'b1;
      {enable_a, en_d_a, up_dn_a, clear_a, load_a} = '0;
      load_val_a = '0;
      {enable_b, en_d_b, up_dn_b, clear_b, load_b} = '0;
      load_val_b = '0;
      {up_dn_c, load_c} = '0;
      load_val_c = '0;
      tick();
      tick();
      chk("rst_cnt_def", int'(cnt_def), 0);
      chk("rst_tc_def", int'(tc_def), 0);
      chk("rst_eo_def", int'(eo_def), 0);
      chk("rst_cnt_pre", int'(cnt_pre), 0);
      reset = 1'b0;
      en_d_a = 1'b1; up_dn_a = 1'b1;
      en_d_b = 1'b1; up_dn_b = 1'b1;
      tick(); tick(); tick();

      // Default wrap counting, with the synchronised copy lagging two clocks
      prev = 0;
      for (int i = 0; i < 6; i++) begin
         enable_a = 1'b1;
         tick();
         chk($sformatf("t1_cnt%0d", i), int'(cnt_def), exp_cnt[i]);
         chk($sformatf("t1_tc%0d", i), int'(tc_def), exp_tc[i]);
         chk($sformatf("t1_eo%0d", i), int'(eo_def), 1);
         chk($sformatf("t1_syn_early%0d", i), int'(cnt_syn), prev);
         tick();
         chk($sformatf("t1_eo_low%0d", i), int'(eo_def), 0);
         chk($sformatf("t1_tc_low%0d", i), int'(tc_def), 0);
         enable_a = 1'b0;
         tick();
         chk($sformatf("t1_syn_cnt%0d", i), int'(cnt_syn), exp_cnt[i]);
         chk($sformatf("t1_syn_tc%0d", i), int'(tc_syn), exp_tc[i]);
         chk($sformatf("t1_syn_eo%0d", i), int'(eo_syn), 1);
         tick();
         chk($sformatf("t1_syn_eo_low%0d", i), int'(eo_syn), 0);
         prev = exp_cnt[i];
      end

      // Prescale by 3 on both edges, 0..9 then wrap to 0
      for (int k = 1; k <= 30; k++) begin
         enable_b = ~enable_b;
         tick();
         chk($sformatf("t2_cnt%0d", k), int'(cnt_pre), (k / 3) % 10);
         chk($sformatf("t2_tc%0d", k), int'(tc_pre), (k == 30) ? 1 : 0);
         tick();
      end

      // Saturating down count from a loaded value
      up_dn_c = 1'b0;
      load_val_c = 3'd2;
      load_c = 1'b1;
      tick();
      load_c = 1'b0;
      chk("t3_load", int'(cnt_sat), 2);
      for (int s = 0; s < 3; s++) begin
         enable_b = 1'b1;
         tick();
         chk($sformatf("t3_cnt%0d", s), int'(cnt_sat), 1);
         chk($sformatf("t3_tc%0d", s), int'(tc_sat), (s == 0) ? 1 : 0);
         tick();
         chk($sformatf("t3_tc_low%0d", s), int'(tc_sat), 0);
         enable_b = 1'b0;
         tick();
         tick();
      end
      load_val_c = 3'd7;
      load_c = 1'b1;
      tick();
      load_c = 1'b0;
      chk("t4_clamp", int'(cnt_sat), 3);
      chk("t4_clamp_tc", int'(tc_sat), 0);

      // Clear and load coincident with an edge, prescaler mid-cycle
      enable_b = 1'b1;
      tick();
      chk("t4_pre_cnt", int'(cnt_pre), 2);
      tick();
      enable_b = 1'b0;
      clear_b = 1'b1;
      load_b = 1'b1;
      load_val_b = 4'd5;
      tick();
      clear_b = 1'b0;
      load_b = 1'b0;
      chk("t4_clr_cnt", int'(cnt_pre), 0);
      chk("t4_clr_tc", int'(tc_pre), 0);
      tick();
      for (int j = 1; j <= 3; j++) begin
         enable_b = ~enable_b;
         tick();
         chk($sformatf("t4_after%0d", j), int'(cnt_pre), (j == 3) ? 1 : 0);
         tick();
      end

      // en_d low forces zero; async reset mid-cycle; no edge from a held-high strobe
      clear_a = 1'b1;
      tick();
      clear_a = 1'b0;
      chk("t5_clear", int'(cnt_def), 0);
      pulse_a("t5_s1", 1, 0);
      pulse_a("t5_s2", 2, 0);
      en_d_a = 1'b0;
      pulse_a("t5_end0", 0, 0);
      en_d_a = 1'b1;
      pulse_a("t5_s3", 1, 0);
      pulse_a("t5_s4", 2, 0);
      pulse_a("t5_s5", 3, 0);
      enable_a = 1'b1;
      tick();
      chk("t5_wrap_cnt", int'(cnt_def), 1);
      chk("t5_wrap_tc", int'(tc_def), 1);
      chk("t5_wrap_eo", int'(eo_def), 1);
      #3;
      reset = 1'b1;
      #1;
      chk("t5_arst_cnt", int'(cnt_def), 0);
      chk("t5_arst_tc", int'(tc_def), 0);
      chk("t5_arst_eo", int'(eo_def), 0);
      #2;
      reset = 1'b0;
      for (int h = 0; h < 4; h++) begin
         tick();
         chk($sformatf("t5_hold_eo%0d", h), int'(eo_def), 0);
         chk($sformatf("t5_hold_cnt%0d", h), int'(cnt_def), 0);
         chk($sformatf("t5_hold_syn%0d", h), int'(eo_syn), 0);
      end
      enable_a = 1'b0;
      tick();
      tick();
      enable_a = 1'b1;
      tick();
      chk("t5_rearm_cnt", int'(cnt_def), 1);
      chk("t5_rearm_eo", int'(eo_def), 1);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
